ucntr_mod: RTL
==============

# ucntr_mod

Synchronous modulo-N up counter with enable, parallel load, synchronous clear, cascade output and sticky status flags. It is the up-counting counterpart to the team's 4-bit down counter. It feeds timebase and sequencing logic that need a count rising from zero, and multiple instances chain through `tc` to build wider counters.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2..16.
- `MODULUS`, default 16: count sequence is 0..MODULUS-1; legal range 2..2^WIDTH.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `clr`  input  1  synchronous clear; highest-priority synchronous command.
- `en`  input  1  count enable; also the cascade input from the lower stage's `tc`.
- `load`  input  1  synchronous parallel load of `d`.
- `d`  input  WIDTH  load value.
- `q`  output  WIDTH  current count, registered.
- `tc`  output  1  combinational terminal count: `en & (q == MODULUS-1)`.
- `wrap`  output  1  registered one-cycle pulse asserted in the cycle after q wraps MODULUS-1 -> 0.
- `ovf`  output  1  sticky: set on any wrap.
- `err`  output  1  sticky: set on a load with `d >= MODULUS`.

## Operation
- Reset values: q=0, wrap=0, ovf=0, err=0. tc=0 while `reset` is high, because q=0 and MODULUS>=2.
- Per-edge command priority (only the highest-priority active command acts):
  - `clr`: q<=0, wrap<=0, ovf<=0, err<=0. The `load` and `en` inputs are ignored.
  - `load`:
    - If d<MODULUS: q<=d.
    - Otherwise: q<=0 and err<=1.
    - wrap<=0. ovf is unchanged. `en` is ignored in the same cycle.
  - `en`:
    - If q==MODULUS-1: q<=0, wrap<=1, ovf<=1.
    - Otherwise: q<=q+1, wrap<=0.
  - None active: q holds, wrap<=0.
- Arithmetic is WIDTH-bit unsigned. The increment never exceeds MODULUS-1, so there is no natural binary rollover except when MODULUS==2^WIDTH, where the wrap is both the binary rollover and the modulus wrap.
- Cascading: the upper stage's `en` connects to the lower stage's `tc`. The upper stage then advances on exactly the edge where the lower stage wraps.
- Sticky flags clear only on `reset` or `clr`. Neither `load` nor a subsequent valid count clears them.
- No internal state other than q, wrap, ovf and err.

## Timing
- Count latency: q reflects a command one clock edge after it is sampled.
- `tc` is combinational from `en` and q with zero latency. It is valid in the same cycle the wrap edge is about to occur.
- `wrap` is high for exactly one cycle, following the edge that moved q from MODULUS-1 to 0.
- Consecutive wraps are possible only when MODULUS cycles elapse between them. With MODULUS=2 and `en` held high, `wrap` pulses every second cycle.
- `reset` asserted mid-count forces q=0 and clears all flags without waiting for a clock edge. On the first edge after reset deasserts, normal priority applies.
- Simultaneous cases:
  - `clr`+`load`+`en` all high: result is clear.
  - `load`+`en` with q==MODULUS-1: result is load; no wrap pulse, and ovf is unchanged.
- `d` is sampled only on edges where `load` is active. It has no combinational path to any output.

## Test plan
- Reset then count, with WIDTH=4, MODULUS=10: hold reset 2 cycles, then hold en=1 for 12 cycles.
  - q = 0,1,...,9,0,1.
  - tc high only while q=9.
  - wrap high for one cycle when q=0 after 9.
  - ovf=1 from that point.
- Load and enable:
  - load d=7 -> q=7, err=0.
  - load with en=1, d=3 at q=9 -> q=3, wrap=0.
  - load d=12 -> q=0, err=1.
- Clear priority: with ovf=1 and err=1, assert clr+load+en with d=5 -> q=0, ovf=0, err=0, wrap=0.
- Hold and async reset:
  - en=0 for 5 cycles at q=4 -> q stays 4, tc=0.
  - Assert reset between edges at q=6 -> q=0 and flags=0 before the next edge.
- Cascade: two instances with WIDTH=4, MODULUS=10, upper en tied to lower tc.
  - Run 100 cycles from 0 with the lower stage's en=1.
  - Upper q advances once every 10 cycles; {upper,lower} steps 00..99 then 00.
  - Upper wrap pulses once at 100.
- Full-range modulus, WIDTH=4, MODULUS=16: count from 15 with en=1 -> q=0, wrap=1, ovf=1. A load with d=15 is accepted with err=0.

Source files
------------

// File: rtl/ucntr_mod.sv
// ucntr_mod: modulo-N up counter with enable, load, clear and cascade tc.
// Sticky ovf/err flags clear only on reset or clr.
module ucntr_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             err
);

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH stays representable.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

    logic at_last;
    logic d_ok;

    assign at_last = (q == LAST);
    assign d_ok    = ({1'b0, d} < MOD_X);
    assign tc      = en & at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
            err  <= 1'b0;
        end else if (clr) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
            err  <= 1'b0;
        end else if (load) begin
            q    <= d_ok ? d : '0;
            wrap <= 1'b0;
            if (!d_ok) begin
                err <= 1'b1;
            end
        end else if (en) begin
            if (at_last) begin
                q    <= '0;
                wrap <= 1'b1;
                ovf  <= 1'b1;
            end else begin
                q    <= q + WIDTH'(1);
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
